// File: rtl/pc_pkg.sv
// Shared definitions for the program counter: default sizes, the per-cycle
// operation encoding and the priority decoder that selects one operation.
package pc_pkg;

    localparam int unsigned PC_WIDTH = 16;
    localparam int unsigned PC_DEPTH = 4;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_INC   = 3'd1,
        OP_LOAD  = 3'd2,
        OP_CALL  = 3'd3,
        OP_RET   = 3'd4,
        OP_CLEAR = 3'd5
    } pc_op_t;

    // Priority: clear > ret > call > load > inc > hold.
    // With no return stack, ret is dropped so the next lower request applies.
    function automatic pc_op_t pc_decode(
        input logic clear,
        input logic ret,
        input logic call,
        input logic load,
        input logic inc,
        input logic stack_en
    );
        pc_op_t op;
        op = OP_HOLD;
        if (clear)                 op = OP_CLEAR;
        else if (ret && stack_en)  op = OP_RET;
        else if (call)             op = OP_CALL;
        else if (load)             op = OP_LOAD;
        else if (inc)              op = OP_INC;
        return op;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses for program_counter.
// Ports:
//   clock, reset_n : clock and async active-low reset (resets depth only)
//   clr            : synchronous empty
//   push, push_data: write push_data on top (ignored when full)
//   pop            : drop top entry (ignored when empty); pop wins over push
//   top_c          : current top entry (combinational read of storage)
//   depth          : registered live entry count
//   full_c, empty_c: combinational status derived from depth
module return_stack #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [N-1:0]               push_data,
    input  logic                       pop,
    output logic [N-1:0]               top_c,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full_c,
    output logic                       empty_c
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]  r_mem [DEPTH];
    logic [DW-1:0] r_depth;
    logic [AW-1:0] w_top_idx;
    logic [AW-1:0] w_wr_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign full_c    = (r_depth == DW'(DEPTH));
    assign empty_c   = (r_depth == '0);
    assign w_do_pop  = pop && !empty_c;
    assign w_do_push = push && !pop && !full_c;

    // Indices are only meaningful when the guarded operation is legal.
    assign w_top_idx = empty_c ? '0 : AW'(r_depth - DW'(1));
    assign w_wr_idx  = full_c  ? '0 : AW'(r_depth);
    assign top_c     = r_mem[w_top_idx];
    assign depth     = r_depth;

    // Entry count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_depth <= '0;
        end else if (clr) begin
            r_depth <= '0;
        end else if (w_do_pop) begin
            r_depth <= r_depth - DW'(1);
        end else if (w_do_push) begin
            r_depth <= r_depth + DW'(1);
        end
    end

    // Storage is not reset; only entries below depth are ever read.
    always_ff @(posedge clock) begin
        if (w_do_push && !clr) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/program_counter.sv
// Program counter with optional return-address stack.
// Build option: define PROGRAM_COUNTER_STACK_EN to include the return stack;
// otherwise call acts as load, ret is ignored and depth/overflow/underflow are 0.
// Ports:
//   clock, reset_n : rising-edge clock, async active-low reset
//   in             : jump/call target
//   load/inc/clear/call/ret : operation requests (priority in pc_decode)
//   out            : registered current address
//   depth          : live stack entries (registered)
//   overflow       : sticky, call while stack full
//   underflow      : sticky, ret while stack empty
module program_counter
    import pc_pkg::*;
#(
    parameter int unsigned N     = PC_WIDTH,
    parameter int unsigned DEPTH = PC_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N-1:0]               in,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       clear,
    input  logic                       call,
    input  logic                       ret,
    output logic [N-1:0]               out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned DW = $clog2(DEPTH + 1);

    pc_op_t       w_op;
    logic [N-1:0] r_out;
    logic [N-1:0] w_out_nxt;
    logic [N-1:0] w_out_inc;
    logic         r_ovf;
    logic         w_ovf_nxt;
    logic         r_unf;
    logic         w_unf_nxt;

`ifdef PROGRAM_COUNTER_STACK_EN
    localparam logic STACK_EN = 1'b1;
`else
    localparam logic STACK_EN = 1'b0;
`endif

    assign w_op      = pc_decode(clear, ret, call, load, inc, STACK_EN);
    assign w_out_inc = r_out + N'(1);

`ifdef PROGRAM_COUNTER_STACK_EN
    logic [N-1:0]  w_top;
    logic [DW-1:0] w_depth;
    logic          w_full;
    logic          w_empty;

    // Return address is the incremented current address.
    return_stack #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_return_stack (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr       (w_op == OP_CLEAR),
        .push      (w_op == OP_CALL),
        .push_data (w_out_inc),
        .pop       (w_op == OP_RET),
        .top_c     (w_top),
        .depth     (w_depth),
        .full_c    (w_full),
        .empty_c   (w_empty)
    );

    assign depth = w_depth;
`else
    assign depth = DW'(0);
`endif

    // Next address and sticky flags for the selected operation.
    always_comb begin
        w_out_nxt = r_out;
        w_ovf_nxt = r_ovf;
        w_unf_nxt = r_unf;
        case (w_op)
            OP_CLEAR: begin
                w_out_nxt = '0;
                w_ovf_nxt = 1'b0;
                w_unf_nxt = 1'b0;
            end
`ifdef PROGRAM_COUNTER_STACK_EN
            OP_RET: begin
                if (w_empty) w_unf_nxt = 1'b1;
                else         w_out_nxt = w_top;
            end
            OP_CALL: begin
                w_out_nxt = in;
                if (w_full) w_ovf_nxt = 1'b1;
            end
`else
            OP_CALL: w_out_nxt = in;
`endif
            OP_LOAD: w_out_nxt = in;
            OP_INC:  w_out_nxt = w_out_inc;
            default: w_out_nxt = r_out;
        endcase
    end

    // Address and flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            r_ovf <= w_ovf_nxt;
            r_unf <= w_unf_nxt;
        end
    end

    assign out       = r_out;
    assign overflow  = STACK_EN & r_ovf;
    assign underflow = STACK_EN & r_unf;

endmodule

// File: tb/tb_program_counter.sv
// Directed test of program_counter (default N=16, DEPTH=4).
module tb_program_counter;

    localparam int unsigned N  = 16;
    localparam int unsigned DW = 3;

    logic          clock;
    logic          reset_n;
    logic [N-1:0]  in;
    logic          load, inc, clear, call, ret;
    logic [N-1:0]  out;
    logic [DW-1:0] depth;
    logic          overflow, underflow;

    int errors = 0;
    int checks = 0;

    program_counter #(.N(16), .DEPTH(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in        (in),
        .load      (load),
        .inc       (inc),
        .clear     (clear),
        .call      (call),
        .ret       (ret),
        .out       (out),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        in = '0; load = 0; inc = 0; clear = 0; call = 0; ret = 0;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [N-1:0] e_out,
                             input logic [DW-1:0] e_dep, input logic e_ovf, input logic e_unf);
        chk({tag, ".out"},   32'(out),       32'(e_out));
        chk({tag, ".depth"}, 32'(depth),     32'(e_dep));
        chk({tag, ".ovf"},   32'(overflow),  32'(e_ovf));
        chk({tag, ".unf"},   32'(underflow), 32'(e_unf));
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic c, input logic r,
                         input logic cl, input logic l, input logic i);
        in = a; call = c; ret = r; clear = cl; load = l; inc = i;
        step();
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #3;
        chk_state("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Async reset mid-cycle.
        do_op(16'h0123, 0, 0, 0, 1, 0);
        chk("rst.pre", 32'(out), 32'h0123);
        #2 reset_n = 1'b0;
        #1;
        chk_state("rst.async", 16'h0000, 3'd0, 1'b0, 1'b0);
        step();
        reset_n = 1'b1;
        inc = 1'b1;
        repeat (3) step();
        idle();
        chk("rst.inc3", 32'(out), 32'h0003);

        // Wrap.
        do_op(16'hFFFF, 0, 0, 0, 1, 0);
        chk("wrap.load", 32'(out), 32'hFFFF);
        do_op(16'h0000, 0, 0, 0, 0, 1);
        chk_state("wrap.inc", 16'h0000, 3'd0, 1'b0, 1'b0);

        // Priority.
        do_op(16'h0010, 0, 0, 0, 1, 0);
        do_op(16'h0555, 1, 1, 1, 1, 1);
        chk_state("prio.all", 16'h0000, 3'd0, 1'b0, 1'b0);
        do_op(16'h0200, 0, 0, 0, 1, 1);
        chk("prio.ld_inc", 32'(out), 32'h0200);
        step(); step();
        chk("hold", 32'(out), 32'h0200);

        // Reset during a pending load discards it.
        in = 16'h0777; load = 1'b1;
        #2 reset_n = 1'b0;
        step();
        idle();
        chk("rst.discard", 32'(out), 32'h0000);
        reset_n = 1'b1;

`ifdef PROGRAM_COUNTER_STACK_EN
        // Call / ret.
        do_op(16'h0100, 0, 0, 0, 1, 0);
        do_op(16'h0800, 1, 0, 0, 0, 0);
        chk_state("call", 16'h0800, 3'd1, 1'b0, 1'b0);
        do_op(16'h0000, 0, 0, 0, 0, 1);
        do_op(16'h0000, 0, 0, 0, 0, 1);
        chk("call.inc2", 32'(out), 32'h0802);
        do_op(16'h0000, 0, 1, 0, 0, 0);
        chk_state("ret", 16'h0101, 3'd0, 1'b0, 1'b0);

        // ret beats call and load.
        do_op(16'h0300, 1, 0, 0, 0, 0);
        chk_state("call2", 16'h0300, 3'd1, 1'b0, 1'b0);
        do_op(16'h0999, 1, 1, 0, 1, 1);
        chk_state("prio.ret", 16'h0102, 3'd0, 1'b0, 1'b0);

        // Bounds: pushes 0x103, 0x11, 0x21, 0x31.
        for (int k = 1; k <= 5; k++) do_op(16'(k * 16), 1, 0, 0, 0, 0);
        chk_state("bnd.call5", 16'h0050, 3'd4, 1'b1, 1'b0);
        do_op(16'h0000, 0, 1, 0, 0, 0);
        chk_state("bnd.ret1", 16'h0031, 3'd3, 1'b1, 1'b0);
        do_op(16'h0000, 0, 1, 0, 0, 0);
        do_op(16'h0000, 0, 1, 0, 0, 0);
        chk_state("bnd.ret3", 16'h0011, 3'd1, 1'b1, 1'b0);
        do_op(16'h0000, 0, 1, 0, 0, 0);
        chk_state("bnd.ret4", 16'h0103, 3'd0, 1'b1, 1'b0);
        do_op(16'h0000, 0, 1, 0, 0, 0);
        chk_state("bnd.ret5", 16'h0103, 3'd0, 1'b1, 1'b1);
        do_op(16'h0000, 0, 0, 0, 0, 1);
        chk_state("bnd.sticky", 16'h0104, 3'd0, 1'b1, 1'b1);
        do_op(16'h0000, 0, 0, 1, 0, 0);
        chk_state("bnd.clear", 16'h0000, 3'd0, 1'b0, 1'b0);

        // Reset during a pending call discards the push.
        in = 16'h0700; call = 1'b1;
        #2 reset_n = 1'b0;
        step();
        idle();
        chk_state("rst.call", 16'h0000, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        do_op(16'h0000, 0, 1, 0, 0, 0);
        chk_state("rst.call.ret", 16'h0000, 3'd0, 1'b0, 1'b1);
`else
        // Without the stack: call is load, ret is ignored.
        do_op(16'h0040, 1, 0, 0, 0, 0);
        chk_state("nostk.call", 16'h0040, 3'd0, 1'b0, 1'b0);
        do_op(16'h0000, 0, 1, 0, 0, 1);
        chk_state("nostk.ret_inc", 16'h0041, 3'd0, 1'b0, 1'b0);
        do_op(16'h0000, 0, 1, 0, 0, 0);
        chk_state("nostk.ret", 16'h0041, 3'd0, 1'b0, 1'b0);
        do_op(16'h0123, 0, 1, 0, 1, 0);
        chk("nostk.ret_ld", 32'(out), 32'h0123);
        for (int k = 1; k <= 6; k++) do_op(16'(k * 16), 1, 0, 0, 0, 0);
        chk_state("nostk.call6", 16'h0060, 3'd0, 1'b0, 1'b0);
        do_op(16'h0000, 0, 0, 1, 0, 0);
        chk("nostk.clear", 32'(out), 32'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL have parameter N, default 16: address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4: return-stack entries, DEPTH >= 1.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clock and reset_n.
REQ-004 The port list SHALL be, one per line:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in  input  N  jump/call target address
- load  input  1  jump to in
- inc  input  1  advance to out+1
- clear  input  1  synchronous clear
- call  input  1  push out+1 and jump to in
- ret  input  1  pop top of stack into out
- out  output  N  registered current address
- depth  output  $clog2(DEPTH+1)  live stack entries
- overflow  output  1  sticky: call while stack full
- underflow  output  1  sticky: ret while stack empty

Function
REQ-005 All outputs SHALL be register outputs, with no combinational path from any input to any output.
REQ-006 Inputs SHALL be sampled on the rising edge of clock and take effect on out in the same edge (one-cycle latency).
REQ-007 Per-cycle priority SHALL be: clear > ret > call > load > inc > hold.
REQ-008 clear SHALL set out=0, depth=0, overflow=0 and underflow=0.
REQ-009 ret with depth>0 SHALL set out to the top entry and decrement depth.
REQ-010 ret with depth=0 SHALL hold out and set underflow.
REQ-011 call with depth<DEPTH SHALL push (out+1) mod 2^N, set out=in and increment depth.
REQ-012 call with depth=DEPTH SHALL leave the stack unchanged, set out=in and set overflow.
REQ-013 load SHALL set out=in.
REQ-014 inc SHALL set out=(out+1) mod 2^N, so all-ones wraps to 0.
REQ-015 With no operation asserted, out, depth and the stack SHALL hold.
REQ-016 overflow and underflow SHALL remain set until clear or reset.

Reset
REQ-017 reset_n low SHALL immediately, independent of clock, force out=0, depth=0, overflow=0 and underflow=0.
REQ-018 Stack entry contents need not be reset.
REQ-019 The first rising edge with reset_n high SHALL apply the normal REQ-007 priority.
REQ-020 Reset asserted mid-call or mid-ret SHALL discard that operation entirely.

Configuration
REQ-021 The macro PROGRAM_COUNTER_STACK_EN SHALL control whether the return stack is compiled in.
REQ-022 With PROGRAM_COUNTER_STACK_EN defined, the block SHALL implement the return stack and REQ-009..REQ-012 in full.
REQ-023 Without PROGRAM_COUNTER_STACK_EN:
- no stack storage SHALL be built
- call SHALL behave exactly as load
- ret SHALL be ignored, so the next lower-priority operation applies
- depth, overflow and underflow SHALL be tied to 0

Structure
REQ-024 The shared package pc_pkg SHALL hold:
- default width constant PC_WIDTH=16
- default depth constant PC_DEPTH=4
- operation enum pc_op_t {OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET, OP_CLEAR}
REQ-025 The priority decode SHALL produce a single pc_op_t value per cycle.
REQ-026 The LIFO SHALL be a sub-module return_stack (parameters N, DEPTH) providing push, pop, top, depth, full and empty.
REQ-027 return_stack SHALL be instantiated only when PROGRAM_COUNTER_STACK_EN is defined.

Verification
REQ-028 Reset test: reset_n low mid-cycle with out=0x0123 -> out=0 and depth=0 before the next edge; release, inc for 3 cycles -> out=3.
REQ-029 Wrap test: load in=0xFFFF, then inc -> out=0x0000, no flag set.
REQ-030 Priority test: clear+ret+call+load+inc all high with out=0x0010 -> out=0, depth=0; then load+inc with in=0x0200 -> out=0x0200.
REQ-031 Call/ret test: at out=0x0100, call in=0x0800 -> out=0x0800, depth=1; inc twice, ret -> out=0x0101, depth=0.
REQ-032 Bounds test: with DEPTH=4, 5 calls -> depth=4 and overflow=1 with the 5th target in out; 5 rets -> 4th ret returns the first pushed address, 5th ret holds out and sets underflow=1; clear -> both flags 0.
REQ-033 Macro-off test: without PROGRAM_COUNTER_STACK_EN, call in=0x0040 -> out=0x0040, depth=0; ret+inc -> out=0x0041.
